uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: frames go out LSB first with optional parity
// and one or two stop bits, back-to-back while the queue holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_50M,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] TMAX      = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop;

    state_t               state_q, state_n;
    logic [TW-1:0]        timer_q, timer_n;
    logic [3:0]           bit_q, bit_n;
    logic [DATA_BITS-1:0] shreg_q, shreg_n;
    logic                 par_q, par_n;
    logic                 tx_q, tx_n;
    logic                 last_tick;

    // Ready looks only at the registered count, so a same-cycle pop never opens a full FIFO.
    assign data_ready = (count != CW'(FIFO_DEPTH));
    assign push       = data_valid && data_ready && !rst;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (push) mem[wr_ptr] <= data;
    end

    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        bit_n     = bit_q;
        shreg_n   = shreg_q;
        par_n     = par_q;
        tx_n      = tx_q;
        pop       = 1'b0;
        last_tick = (timer_q == TMAX);
        if (state_q != IDLE) timer_n = last_tick ? '0 : timer_q + TW'(1);
        case (state_q)
            IDLE: tx_n = 1'b1;
            START: begin
                if (last_tick) begin
                    state_n = DATA;
                    tx_n    = shreg_q[0];
                end
            end
            DATA: begin
                if (last_tick) begin
                    if (bit_q == LAST_BIT) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = PAR;
                            tx_n    = par_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_q + 4'd1;
                        shreg_n = shreg_q >> 1;
                        tx_n    = shreg_q[1];
                    end
                end
            end
            PAR: begin
                if (last_tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_n   = '0;
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_q + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Start a frame from idle, or straight out of the final stop bit with no gap.
        if (state_n == IDLE && count != '0) begin
            pop     = 1'b1;
            state_n = START;
            timer_n = '0;
            bit_n   = '0;
            shreg_n = head;
            par_n   = (^head) ^ (PARITY == 1);
            tx_n    = 1'b0;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            bit_q   <= bit_n;
            tx_q    <= tx_n;
        end
    end

    always_ff @(posedge clk_50M) begin
        shreg_q <= shreg_n;
        par_q   <= par_n;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (default, even/odd parity, two stop bits)
// share one stimulus; each test watches the instance it cares about.
module tb_uart_tx_fifo;

    localparam int CLKS = 434;

    logic       clk_50M = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       data_valid;
    logic       ready_w [4];
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic [2:0] cnt_w   [4];

    int tests = 0;
    int fails = 0;

    always #10 clk_50M = ~clk_50M;

    uart_tx_fifo #(.CLKS_PER_BIT(CLKS)) u_def (
        .clk_50M(clk_50M), .rst(rst), .data(data), .data_valid(data_valid),
        .data_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .PARITY(2)) u_even (
        .clk_50M(clk_50M), .rst(rst), .data(data), .data_valid(data_valid),
        .data_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .PARITY(1)) u_odd (
        .clk_50M(clk_50M), .rst(rst), .data(data), .data_valid(data_valid),
        .data_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .STOP_BITS(2)) u_stop2 (
        .clk_50M(clk_50M), .rst(rst), .data(data), .data_valid(data_valid),
        .data_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

    task automatic do_reset();
        data_valid = 1'b0;
        data       = 8'h00;
        rst        = 1'b1;
        repeat (3) @(negedge clk_50M);
        rst = 1'b0;
        @(negedge clk_50M);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b1;
        data       = 8'h55;
        repeat (3) @(negedge clk_50M);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || cnt_w[i] !== 3'd0 || ready_w[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset_state[%0d]: tx=%b busy=%b count=%0d ready=%b, required tx=1 busy=0 count=0 ready=1",
                         i, tx_w[i], busy_w[i], cnt_w[i], ready_w[i]);
            end
        end
        rst        = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(negedge clk_50M);
        tests++;
        if (cnt_w[0] !== 3'd0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL valid_during_reset: count=%0d tx=%b busy=%b, required count=0 tx=1 busy=0",
                     cnt_w[0], tx_w[0], busy_w[0]);
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] lv;
        int bad;
        lv = 10'b1110110110;  // 0,1,1,0,1,1,0,1,1,1 in time order from bit 0
        do_reset();
        data = 8'hDB; data_valid = 1'b1;
        @(negedge clk_50M);
        data_valid = 1'b0;
        tests++;
        if (tx_w[0] !== 1'b1 || cnt_w[0] !== 3'd1) begin
            fails++;
            $display("FAIL single_latency1: tx=%b count=%0d, required tx=1 count=1", tx_w[0], cnt_w[0]);
        end
        @(negedge clk_50M);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < CLKS; c++) begin
                if (tx_w[0] !== lv[b] || busy_w[0] !== 1'b1) begin
                    if (bad == 0)
                        $display("FAIL single_bit%0d: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                                 b, c, tx_w[0], busy_w[0], lv[b]);
                    bad++;
                end
                @(negedge clk_50M);
            end
            tests++;
            if (bad != 0) fails++;
        end
        tests++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) begin
            fails++;
            $display("FAIL single_end: tx=%b busy=%b count=%0d, required tx=1 busy=0 count=0",
                     tx_w[0], busy_w[0], cnt_w[0]);
        end
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
            @(negedge clk_50M);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL single_idle_after: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_parity();
        logic [10:0] lv;
        int bad;
        for (int k = 1; k <= 2; k++) begin
            // Six ones in 8'hDB: even parity bit 0, odd parity bit 1.
            lv = (k == 1) ? 11'b10110110110 : 11'b11110110110;
            do_reset();
            data = 8'hDB; data_valid = 1'b1;
            @(negedge clk_50M);
            data_valid = 1'b0;
            @(negedge clk_50M);
            for (int b = 0; b < 11; b++) begin
                bad = 0;
                for (int c = 0; c < CLKS; c++) begin
                    if (tx_w[k] !== lv[b] || busy_w[k] !== 1'b1) begin
                        if (bad == 0)
                            $display("FAIL parity%0d_bit%0d: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                                     k, b, c, tx_w[k], busy_w[k], lv[b]);
                        bad++;
                    end
                    @(negedge clk_50M);
                end
                tests++;
                if (bad != 0) fails++;
            end
            tests++;
            if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
                fails++;
                $display("FAIL parity%0d_length: tx=%b busy=%b after 4774 cycles, required tx=1 busy=0",
                         k, tx_w[k], busy_w[k]);
            end
        end
    endtask

    task automatic test_stop_bits();
        logic [10:0] lv [2];
        int bad;
        lv[0] = 11'b11000000000;
        lv[1] = 11'b11111111110;
        do_reset();
        data = 8'h00; data_valid = 1'b1;
        @(negedge clk_50M);
        data = 8'hFF;
        @(negedge clk_50M);
        data_valid = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 11; b++) begin
                bad = 0;
                for (int c = 0; c < CLKS; c++) begin
                    if (tx_w[3] !== lv[f][b] || busy_w[3] !== 1'b1) begin
                        if (bad == 0)
                            $display("FAIL stop2_frame%0d_bit%0d: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                                     f, b, c, tx_w[3], busy_w[3], lv[f][b]);
                        bad++;
                    end
                    @(negedge clk_50M);
                end
                tests++;
                if (bad != 0) fails++;
            end
        end
        tests++;
        if (tx_w[3] !== 1'b1 || busy_w[3] !== 1'b0) begin
            fails++;
            $display("FAIL stop2_end: tx=%b busy=%b, required tx=1 busy=0", tx_w[3], busy_w[3]);
        end
    endtask

    task automatic test_fifo_full();
        logic [9:0] fr [5];
        int bad;
        fr[0] = {1'b1, 8'hA5, 1'b0};
        fr[1] = {1'b1, 8'h3C, 1'b0};
        fr[2] = {1'b1, 8'h81, 1'b0};
        fr[3] = {1'b1, 8'h5A, 1'b0};
        fr[4] = {1'b1, 8'hF0, 1'b0};
        do_reset();
        data = 8'hA5; data_valid = 1'b1;
        tests++;
        if (ready_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL fifo_ready_empty: ready=%b, required 1", ready_w[0]);
        end
        @(negedge clk_50M);
        data = 8'h3C;
        @(negedge clk_50M);
        fork
            begin
                for (int f = 0; f < 5; f++) begin
                    bad = 0;
                    for (int b = 0; b < 10; b++) begin
                        for (int c = 0; c < CLKS; c++) begin
                            if (tx_w[0] !== fr[f][b] || busy_w[0] !== 1'b1) begin
                                if (bad == 0)
                                    $display("FAIL fifo_frame%0d: bit %0d cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                                             f, b, c, tx_w[0], busy_w[0], fr[f][b]);
                                bad++;
                            end
                            @(negedge clk_50M);
                        end
                    end
                    tests++;
                    if (bad != 0) fails++;
                end
            end
            begin
                tests++;
                if (tx_w[0] !== 1'b0 || cnt_w[0] !== 3'd1) begin
                    fails++;
                    $display("FAIL fifo_push_pop_same_edge: tx=%b count=%0d, required tx=0 count=1",
                             tx_w[0], cnt_w[0]);
                end
                data = 8'h81;
                @(negedge clk_50M);
                data = 8'h5A;
                @(negedge clk_50M);
                data = 8'hF0;
                @(negedge clk_50M);
                tests++;
                if (cnt_w[0] !== 3'd4 || ready_w[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL fifo_full: count=%0d ready=%b, required count=4 ready=0", cnt_w[0], ready_w[0]);
                end
                data = 8'hEE;
                @(negedge clk_50M);
                data_valid = 1'b0;
                tests++;
                if (cnt_w[0] !== 3'd4) begin
                    fails++;
                    $display("FAIL fifo_sixth_ignored: count=%0d, required 4", cnt_w[0]);
                end
                repeat (4335) @(negedge clk_50M);
                tests++;
                if (cnt_w[0] !== 3'd4 || ready_w[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL fifo_before_pop: count=%0d ready=%b, required count=4 ready=0",
                             cnt_w[0], ready_w[0]);
                end
                data = 8'h77; data_valid = 1'b1;
                @(negedge clk_50M);
                data_valid = 1'b0;
                tests++;
                if (cnt_w[0] !== 3'd3 || ready_w[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL fifo_push_on_pop_edge: count=%0d ready=%b, required count=3 ready=1",
                             cnt_w[0], ready_w[0]);
                end
            end
        join
        tests++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) begin
            fails++;
            $display("FAIL fifo_drained: tx=%b busy=%b count=%0d, required tx=1 busy=0 count=0",
                     tx_w[0], busy_w[0], cnt_w[0]);
        end
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
            @(negedge clk_50M);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL fifo_no_extra_frame: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        do_reset();
        data = 8'h00; data_valid = 1'b1;
        @(negedge clk_50M);
        data = 8'h11;
        @(negedge clk_50M);
        data = 8'h22;
        @(negedge clk_50M);
        data_valid = 1'b0;
        tests++;
        if (cnt_w[0] !== 3'd2) begin
            fails++;
            $display("FAIL midreset_queued: count=%0d, required 2", cnt_w[0]);
        end
        repeat (999) @(negedge clk_50M);
        tests++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: tx=%b busy=%b at frame cycle 1000, required tx=0 busy=1",
                     tx_w[0], busy_w[0]);
        end
        #2;
        rst = 1'b1;
        data = 8'h33; data_valid = 1'b1;
        #1;
        tests++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0 || ready_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL midreset_async: tx=%b busy=%b count=%0d ready=%b, required tx=1 busy=0 count=0 ready=1",
                     tx_w[0], busy_w[0], cnt_w[0], ready_w[0]);
        end
        repeat (3) @(negedge clk_50M);
        data_valid = 1'b0;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) bad++;
            @(negedge clk_50M);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midreset_quiet: %0d cycles with activity after release, required 0", bad);
        end
    endtask

    initial begin
        rst        = 1'b1;
        data       = 8'h00;
        data_valid = 1'b0;
        test_reset();
        test_single_frame();
        test_parity();
        test_stop_bits();
        test_fifo_full();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
